rom_arbiter: RTL and testbench

Shares the single synchronous instruction/constant ROM between the core's instruction-fetch port and its data-load port. Arbitrates per cycle, with data having priority and a starvation guard for fetch. Drives the ROM's byte address and routes the 1-cycle-late read data back to the port that issued it. Holds each response until its requester accepts it. Sits between the core's IF/MEM stages and the `rom` instance.

---
 rtl/rom_arb_pkg.sv | 14 +
 rtl/rom_arbiter_if.sv | 33 +++
 rtl/rom_rsp_hold.sv | 53 +++++
 rtl/rom_arbiter.sv | 108 ++++++++++
 tb/tb_rom_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the instruction/constant ROM arbiter: port identifiers
// and the per-port response bundle.
package rom_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response handshakes of the fetch and data-load ports toward the ROM arbiter.
interface rom_arbiter_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

endinterface

// File: rtl/rom_rsp_hold.sv
// Per-port response path: bypasses ROM data in the tag cycle and parks it in a
// hold register while the requester is not ready.
module rom_rsp_hold
  import rom_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tag_hit,
  input  logic        tag_err,
  input  logic [31:0] rom_rdata,
  input  logic        rsp_ready,
  output rsp_t        rsp,
  output logic        eligible
);

  logic        hold_v;
  logic [31:0] hold_data;
  logic        hold_err;
  logic        rsp_valid;
  logic        capture;

  // Anything in flight or held while rst is high is dropped, never presented.
  assign rsp_valid = !rst && (hold_v || tag_hit);
  assign capture   = tag_hit && !hold_v && !rsp_ready;
  assign eligible  = !rsp_valid || rsp_ready;

  always_comb begin
    rsp = '0;
    if (rsp_valid) begin
      rsp.valid = 1'b1;
      rsp.data  = hold_v ? hold_data : rom_rdata;
      rsp.err   = hold_v ? hold_err : tag_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
    end else if (capture) begin
      hold_v <= 1'b1;
    end else if (hold_v && rsp_ready) begin
      hold_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_data <= rom_rdata;
      hold_err  <= tag_err;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one 1-cycle-latency ROM between instruction fetch and data loads:
// data-first arbitration with a fetch starvation guard, response routing by tag.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus,
  output logic [31:0]  rom_addr,
  input  logic [31:0]  rom_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        if_elig;
  logic        d_elig;
  logic        if_grant;
  logic        d_grant;
  logic        any_grant;
  logic [31:0] last_addr_p1;
  logic        tag_v_p1;
  logic        tag_port_p1;
  logic        tag_err_p1;
  rsp_t        if_rsp;
  rsp_t        d_rsp;
  logic        if_err_unused;

  // Stage p0: arbitration and ROM address.
  assign starve_hit = (starve_cnt == LIMIT);

  assign bus.d_req_ready  = !rst && d_elig &&
                            !(starve_hit && bus.if_req_valid && if_elig);
  assign bus.if_req_ready = !rst && if_elig &&
                            (starve_hit || !(bus.d_req_valid && d_elig));

  assign d_grant   = bus.d_req_valid && bus.d_req_ready;
  assign if_grant  = bus.if_req_valid && bus.if_req_ready;
  assign any_grant = d_grant || if_grant;

  always_comb begin
    rom_addr = last_addr_p1;
    if (d_grant) begin
      rom_addr = bus.d_req_addr;
    end else if (if_grant) begin
      rom_addr = bus.if_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_p1     <= 1'b0;
      starve_cnt   <= '0;
      last_addr_p1 <= '0;
    end else begin
      tag_v_p1 <= any_grant;
      if (!bus.if_req_valid || if_grant) begin
        starve_cnt <= '0;
      end else if (d_grant && !starve_hit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (any_grant) begin
        last_addr_p1 <= rom_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (any_grant) begin
      tag_port_p1 <= d_grant ? PORT_D : PORT_IF;
      tag_err_p1  <= d_grant && (bus.d_req_addr[1:0] != 2'b00);
    end
  end

  // Stage p1: ROM data returns and is routed to the tagged port.
  rom_rsp_hold u_hold_if (
    .clk       (clk),
    .rst       (rst),
    .tag_hit   (tag_v_p1 && (tag_port_p1 == PORT_IF)),
    .tag_err   (1'b0),
    .rom_rdata (rom_rdata),
    .rsp_ready (bus.if_rsp_ready),
    .rsp       (if_rsp),
    .eligible  (if_elig)
  );

  rom_rsp_hold u_hold_d (
    .clk       (clk),
    .rst       (rst),
    .tag_hit   (tag_v_p1 && (tag_port_p1 == PORT_D)),
    .tag_err   (tag_err_p1),
    .rom_rdata (rom_rdata),
    .rsp_ready (bus.d_rsp_ready),
    .rsp       (d_rsp),
    .eligible  (d_elig)
  );

  assign bus.if_rsp_valid = if_rsp.valid;
  assign bus.if_rsp_data  = if_rsp.data;
  assign if_err_unused    = if_rsp.err;
  assign bus.d_rsp_valid  = d_rsp.valid;
  assign bus.d_rsp_data   = d_rsp.data;
  assign bus.d_rsp_err    = d_rsp.err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenario tasks plus a response scoreboard fed
// from a behavioural ROM model.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] if_q[$];
  logic [32:0] d_q[$];

  always #5 clk = ~clk;

  rom_arbiter_if bus();

  rom_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {8'hA5, a[9:2], ~a[9:2], a[9:2] ^ 8'h3C};
  endfunction

  always @(posedge clk) rom_rdata <= word_at(rom_addr);

  // Scoreboard: accepted responses are popped before this cycle's grants are pushed.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      if_q.delete();
      d_q.delete();
    end else begin
      if (bus.if_rsp_valid && bus.if_rsp_ready) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL sb_if_unexpected: got data %h, expected no response", bus.if_rsp_data);
        end else begin
          e = if_q.pop_front();
          if (bus.if_rsp_data !== e[31:0]) begin
            errors++;
            $display("FAIL sb_if_data: got %h, expected %h", bus.if_rsp_data, e[31:0]);
          end
        end
      end
      if (bus.d_rsp_valid && bus.d_rsp_ready) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL sb_d_unexpected: got data %h, expected no response", bus.d_rsp_data);
        end else begin
          e = d_q.pop_front();
          if ({bus.d_rsp_err, bus.d_rsp_data} !== e) begin
            errors++;
            $display("FAIL sb_d_data: got err=%b data=%h, expected err=%b data=%h",
                     bus.d_rsp_err, bus.d_rsp_data, e[32], e[31:0]);
          end
        end
      end
      if (bus.if_req_valid && bus.if_req_ready)
        if_q.push_back({1'b0, word_at(bus.if_req_addr)});
      if (bus.d_req_valid && bus.d_req_ready)
        d_q.push_back({bus.d_req_addr[1:0] != 2'b00, word_at(bus.d_req_addr)});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 32'h0;
    bus.if_rsp_ready = 1'b1;
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = 32'h0;
    bus.d_rsp_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.if_req_valid = 1'b1;
    bus.d_req_valid  = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.if_req_ready, bus.d_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got if=%b d=%b, expected 0 0", bus.if_req_ready, bus.d_req_ready);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.d_rsp_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rsp_valid: got if=%b d=%b err=%b, expected 0", bus.if_rsp_valid, bus.d_rsp_valid, bus.d_rsp_err);
    end
    checks++;
    if ({bus.if_rsp_data, bus.d_rsp_data, rom_addr} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got if=%h d=%h rom_addr=%h, expected 0", bus.if_rsp_data, bus.d_rsp_data, rom_addr);
    end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if (bus.if_req_ready !== 1'b1 || rom_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_grant: got ready=%b rom_addr=%h, expected 1 00000010", bus.if_req_ready, rom_addr);
    end
    next_cycle();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== word_at(32'h10)) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b data=%h, expected 1 %h", bus.if_rsp_valid, bus.if_rsp_data, word_at(32'h10));
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rom_addr !== 32'h10 || bus.if_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got rom_addr=%h valid=%b, expected 00000010 0", rom_addr, bus.if_rsp_valid);
    end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h20;
    bus.d_req_valid  = 1'b1;
    bus.d_req_addr   = 32'h40;
    @(negedge clk);
    checks++;
    if ({bus.d_req_ready, bus.if_req_ready} !== 2'b10 || rom_addr !== 32'h40) begin
      errors++;
      $display("FAIL simul_n: got d=%b if=%b rom_addr=%h, expected 1 0 00000040", bus.d_req_ready, bus.if_req_ready, rom_addr);
    end
    next_cycle();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== word_at(32'h40)) begin
      errors++;
      $display("FAIL simul_d_rsp: got valid=%b data=%h, expected 1 %h", bus.d_rsp_valid, bus.d_rsp_data, word_at(32'h40));
    end
    checks++;
    if (bus.if_req_ready !== 1'b1 || rom_addr !== 32'h20) begin
      errors++;
      $display("FAIL simul_if_grant: got ready=%b rom_addr=%h, expected 1 00000020", bus.if_req_ready, rom_addr);
    end
    next_cycle();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== word_at(32'h20)) begin
      errors++;
      $display("FAIL simul_if_rsp: got valid=%b data=%h, expected 1 %h", bus.if_rsp_valid, bus.if_rsp_data, word_at(32'h20));
    end
  endtask

  task automatic test_starvation();
    int denied = 0;
    int max_denied = 0;
    for (int k = 0; k < 12; k++) begin
      logic exp_if;
      next_cycle();
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h100 + 32'(4 * k);
      bus.d_req_valid  = 1'b1;
      bus.d_req_addr   = 32'h200 + 32'(4 * k);
      exp_if = ((k % 5) == 4);
      @(negedge clk);
      checks++;
      if (bus.if_req_ready !== exp_if || bus.d_req_ready !== !exp_if) begin
        errors++;
        $display("FAIL starve_pattern[%0d]: got if=%b d=%b, expected if=%b d=%b", k, bus.if_req_ready, bus.d_req_ready, exp_if, !exp_if);
      end
      if (bus.if_req_ready === 1'b1) denied = 0;
      else denied++;
      if (denied > max_denied) max_denied = denied;
    end
    checks++;
    if (max_denied > 4) begin
      errors++;
      $display("FAIL starve_max_denied: got %0d, expected at most 4", max_denied);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_backpressure();
    next_cycle();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h300;
    bus.d_req_valid  = 1'b1;
    bus.d_req_addr   = 32'h80;
    bus.d_rsp_ready  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_grant: got %b, expected 1", bus.d_req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus.d_req_addr = 32'h84;
      @(negedge clk);
      checks++;
      if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== word_at(32'h80)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h, expected 1 %h", k, bus.d_rsp_valid, bus.d_rsp_data, word_at(32'h80));
      end
      checks++;
      if ({bus.d_req_ready, bus.if_req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got d=%b if=%b, expected 0 1", k, bus.d_req_ready, bus.if_req_ready);
      end
    end
    next_cycle();
    bus.d_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || {bus.d_req_ready, bus.if_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got valid=%b d=%b if=%b, expected 1 1 0", bus.d_rsp_valid, bus.d_req_ready, bus.if_req_ready);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== word_at(32'h84)) begin
      errors++;
      $display("FAIL bp_next_rsp: got valid=%b data=%h, expected 1 %h", bus.d_rsp_valid, bus.d_rsp_data, word_at(32'h84));
    end
    next_cycle();
  endtask

  task automatic test_misaligned();
    next_cycle();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h43;
    next_cycle();
    bus.d_req_addr  = 32'h44;
    @(negedge clk);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_err !== 1'b1 || bus.d_rsp_data !== word_at(32'h40)) begin
      errors++;
      $display("FAIL misaligned_rsp: got valid=%b err=%b data=%h, expected 1 1 %h", bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data, word_at(32'h40));
    end
    next_cycle();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_err !== 1'b0 || bus.d_rsp_data !== word_at(32'h44)) begin
      errors++;
      $display("FAIL aligned_rsp: got valid=%b err=%b data=%h, expected 1 0 %h", bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data, word_at(32'h44));
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h94;
    bus.d_req_valid  = 1'b1;
    bus.d_req_addr   = 32'h90;
    bus.d_rsp_ready  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: got %b, expected 1", bus.d_req_ready);
    end
    next_cycle();
    rst = 1'b1;
    idle();
    bus.d_rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_req_ready, bus.d_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_ready: got if=%b d=%b, expected 0 0", bus.if_req_ready, bus.d_req_ready);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b00 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_after: got if=%b d=%b rom_addr=%h, expected 0 0 00000000", bus.if_rsp_valid, bus.d_rsp_valid, rom_addr);
    end
    checks++;
    if (dut.starve_cnt !== 4'd0 || dut.u_hold_d.hold_v !== 1'b0 || dut.u_hold_if.hold_v !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: got starve=%0d hold_d=%b hold_if=%b, expected 0 0 0", dut.starve_cnt, dut.u_hold_d.hold_v, dut.u_hold_if.hold_v);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_late: got if=%b d=%b, expected 0 0", bus.if_rsp_valid, bus.d_rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_misaligned();
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d fetch and %0d data pending, expected 0", if_q.size(), d_q.size());
    end
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
